score_bcd: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3) that sits directly upstream of the on-screen digit renderer. It turns the 12-bit game score into four decimal digit codes, one per glyph slot. This replaces per-pixel division in the display path with one conversion per frame. Top level pulses start once per frame (at vsync); the renderer reads the held digits.

---
 rtl/score_bcd.sv | 132 +++++++++++++
 tb/tb_score_bcd.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd.sv
// -----------------------------------------------------------------------------
// score_bcd
//   Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
//   Converts the binary game score into DIGITS decimal digit codes once per
//   frame, so the glyph renderer never has to divide per pixel.
//
//   Handshake: start is sampled only while idle (busy=0). An accepted request
//   captures bin on that edge. busy stays high through the BIN_W shift cycles
//   and the final DONE cycle. digits, done and valid all update together on
//   the DONE edge: done is a one-cycle pulse, valid stays high from the first
//   completed conversion until reset. Requests that arrive while busy are
//   dropped, not queued.
//
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-high
//   start   conversion request (sampled in IDLE only)
//   bin     binary score, BIN_W bits (captured on the accepting edge)
//   busy    conversion in progress (SHIFT or DONE)
//   done    one-cycle pulse: digits was just updated
//   valid   at least one conversion has completed since reset
//   digits  BCD result, DIGITS nibbles, most significant nibble first
// -----------------------------------------------------------------------------
module score_bcd #(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   digits
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   // The largest binary input must fit in DIGITS decimal digits, otherwise
   // significant bits would fall off the top of the accumulator.
   generate
      if (((64'd1 << BIN_W) - 64'd1) >= 64'(10 ** DIGITS)) begin : g_range_err
         $error("score_bcd: 2**BIN_W-1 does not fit in DIGITS decimal digits");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [BIN_W-1:0]    shift_reg;
   logic [BCD_W-1:0]    bcd;
   logic [BCD_W-1:0]    bcd_adj;
   logic [CNT_W-1:0]    cnt;
   logic                last_shift;

   assign last_shift = (cnt == CNT_W'(BIN_W - 1));
   assign busy       = (state != IDLE);

   // Add-3 correction: each nibble independently, no carry between nibbles.
   // A nibble >= 5 would exceed 9 after doubling, so it is pre-biased by 3.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)      state_next = SHIFT;
         SHIFT:   if (last_shift) state_next = DONE;
         DONE:                    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         bcd       <= '0;
         cnt       <= '0;
         digits    <= '0;
         done      <= 1'b0;
         valid     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= bin;
                  bcd       <= '0;
                  cnt       <= '0;
               end
            end
            SHIFT: begin
               // Corrected accumulator shifts left; bin MSB enters bcd[0].
               // The bit leaving bcd's top is always 0 given the range check.
               {bcd, shift_reg} <= {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
               cnt              <= cnt + CNT_W'(1);
            end
            DONE: begin
               digits <= bcd;
               done   <= 1'b1;
               valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_score_bcd.sv
// -----------------------------------------------------------------------------
// tb_score_bcd
//   Bench for score_bcd (BIN_W=12, DIGITS=4). Drivers push the expected digits
//   into exp_q when a conversion is accepted; the monitor pops one entry for
//   every done pulse and also checks that digits stays put while busy.
// -----------------------------------------------------------------------------
module tb_score_bcd;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] bin;
   logic        busy;
   logic        done;
   logic        valid;
   logic [15:0] digits;

   score_bcd #(.BIN_W(12), .DIGITS(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .valid  (valid),
      .digits (digits)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];
   int          done_cnt = 0;
   int          acc_cyc  = 0;
   logic [15:0] last_digits = 16'h0;
   logic        prev_done   = 1'b0;
   logic [15:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         last_digits = 16'h0;
         prev_done   = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: digits 0x%0h with nothing expected at cycle %0d",
                        digits, cyc);
            end else begin
               mon_exp = exp_q.pop_front();
               check("digits", 32'(digits), 32'(mon_exp));
            end
            check("nibbles_le_9",
                  32'((digits[3:0] <= 4'd9) && (digits[7:4] <= 4'd9) &&
                      (digits[11:8] <= 4'd9) && (digits[15:12] <= 4'd9)), 32'd1);
            last_digits = digits;
         end else if (busy) begin
            check("digits_held", 32'(digits), 32'(last_digits));
         end
         prev_done = done;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_conv(input logic [11:0] b, input logic [15:0] e);
      @(negedge clk);
      start = 1'b1;
      bin   = b;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      start   = 1'b0;
      bin     = 12'($urandom);   // later bin changes must not matter
      exp_q.push_back(e);
   endtask

   task automatic wait_done(output int done_cyc, output int busy_cnt);
      busy_cnt = 0;
      done_cyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      if (done_cyc < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: no done within 40 cycles, acc at %0d", acc_cyc);
      end
   endtask

   // ---------------- stimulus ----------------
   int dc, bc, dc1, dc2, d0, busy_seen;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      bin   = 12'd0;
      repeat (2) @(negedge clk);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_done",   32'(done),   32'd0);
      check("rst_valid",  32'(valid),  32'd0);
      check("rst_digits", 32'(digits), 32'd0);
      rst = 1'b0;

      // T1: zero
      start_conv(12'd0, 16'h0000);
      wait_done(dc, bc);
      check("t1_latency", 32'(dc - acc_cyc), 32'd13);
      check("t1_valid",   32'(valid),        32'd1);

      // T2: full scale
      start_conv(12'd4095, 16'h4095);
      wait_done(dc, bc);
      check("t2_latency",    32'(dc - acc_cyc), 32'd13);
      check("t2_busy_cycles", 32'(bc),          32'd13);
      @(negedge clk);
      check("t2_done_low",   32'(done),         32'd0);

      // T3: start held high, back-to-back conversions
      @(negedge clk);
      start = 1'b1;
      bin   = 12'd1234;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      bin     = 12'd1000;
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'h1000);
      wait_done(dc1, bc);
      check("t3_latency1", 32'(dc1 - acc_cyc), 32'd13);
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = 12'd3333;
      check("t3_busy_second",  32'(busy),   32'd1);
      check("t3_digits_mid",   32'(digits), 32'h1234);
      wait_done(dc2, bc);
      check("t3_done_spacing", 32'(dc2 - dc1), 32'd14);

      // T4: start pulses during SHIFT and DONE are ignored
      start_conv(12'd9, 16'h0009);
      d0 = done_cnt;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         start = (k == 3) || (k == 13);
         bin   = 12'd77;
      end
      @(negedge clk);
      start = 1'b0;
      busy_seen = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (busy) busy_seen++;
      end
      check("t4_no_restart", 32'(busy_seen),      32'd0);
      check("t4_one_done",   32'(done_cnt - d0),  32'd1);
      check("t4_digits",     32'(digits),         32'h0009);

      // T5: asynchronous reset aborts a conversion
      start_conv(12'd555, 16'h0555);
      d0 = done_cnt;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_busy",   32'(busy),   32'd0);
      check("t5_digits", 32'(digits), 32'd0);
      check("t5_valid",  32'(valid),  32'd0);
      check("t5_done",   32'(done),   32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);
      start_conv(12'd555, 16'h0555);
      wait_done(dc, bc);
      check("t5_latency", 32'(dc - acc_cyc), 32'd13);

      // T6: full sweep
      for (int i = 0; i < 4096; i++) begin
         start_conv(12'(i), to_bcd(i));
         wait_done(dc, bc);
         check("sweep_latency", 32'(dc - acc_cyc), 32'd13);
      end

      repeat (5) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
